seq_divider: RTL and testbench
==============================

# seq_divider

Shared multi-cycle unsigned divider serving the bike-computer datapath (average speed and other rate calculations). It accepts a dividend/divisor pair from whichever client currently owns the divider port and computes one quotient bit per clock with a restoring algorithm. Progress is reported on a Busy/Ready handshake, and the quotient is returned saturated to the client result width. The block is the responder end of the divider interface that the rate-calculation blocks drive.

## Interface
- WIDTH_N, 26: dividend width and iteration count.
- WIDTH_D, 26: divisor width.
- WIDTH_Q, 16: returned quotient width (saturated).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- en  in  1  clock enable; when low all state holds.
- go  in  1  explicit start request, sampled only when idle.
- dividend  in  WIDTH_N  unsigned dividend.
- divisor  in  WIDTH_D  unsigned divisor.
- busy  out  1  high while an operation is in progress.
- ready  out  1  result valid; held until the next operation is accepted.
- quotient  out  WIDTH_Q  saturated quotient.
- remainder  out  WIDTH_D  remainder of the full-width division.
- sat  out  1  full quotient exceeded 2^WIDTH_Q-1, or divide by zero.
- dbz  out  1  divisor was zero.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE. Reset values: busy=0, ready=0, quotient=0, remainder=0, sat=0, dbz=0. The last-operand registers and the iteration counter also reset to 0.
- Start condition, evaluated in IDLE or DONE with en=1: go=1, or the current dividend/divisor differ from the last-accepted pair. When the condition holds:
  - latch both operands;
  - clear ready, sat and dbz;
  - set busy=1 and counter=0;
  - enter RUN.
- Operand-change detection lets a client start the divider just by writing new operands while busy=0. A repeated identical pair requires go.
- RUN, one step per enabled cycle (partial remainder R is WIDTH_D+1 bits):
  - R' = {R, next dividend MSB};
  - if R' >= divisor, then R = R' - divisor and the quotient bit is 1; otherwise R = R' and the bit is 0;
  - the full WIDTH_N-bit quotient accumulates internally.
- After WIDTH_N steps, enter DONE with busy=0 and ready=1.
  - quotient = min(full quotient, 2^WIDTH_Q-1); sat=1 if clamped.
  - remainder = R[WIDTH_D-1:0].
- Divide by zero: detected at acceptance. The block still runs the full WIDTH_N cycles. Results: quotient = all ones, remainder = latched dividend, dbz=1, sat=1.
- DONE holds its outputs until a new start condition is met. A start accepted from DONE clears ready in the same edge that sets busy.
- en=0: all registers hold, including the counter in RUN. No start is accepted.
- rst has priority over en and go. rst during RUN aborts the operation and returns all outputs to their reset values.
- go asserted while busy=1 is ignored and is not queued. Operand changes during RUN do not affect the current result; the operands are latched at acceptance.

## Timing
- Acceptance happens at edge k. busy=1 is visible after edge k.
- The RUN steps occur at edges k+1 through k+WIDTH_N. Default latency is 26 enabled cycles from acceptance to ready=1 and busy=0, both visible after edge k+26.
- Each en=0 cycle during RUN adds exactly one cycle of latency.
- busy and ready are never high together. Both are low only in IDLE after reset.
- Client sequence: wait for busy=0, drive the operands (and go if the pair is unchanged), wait for busy=1, then wait for ready=1 and sample quotient in that cycle or any later cycle before the next start.
- Back-to-back: a new start is accepted in the first cycle of DONE. The minimum issue interval is WIDTH_N+1 cycles.

## Test plan
- dividend=123456, divisor=100, go pulse → busy=1 after 1 edge. ready=1 26 cycles after acceptance with quotient=1234, remainder=56, sat=0, dbz=0.
- dividend=10000000, divisor=10 → quotient=0xFFFF, sat=1, dbz=0, remainder=0.
- dividend=50000, divisor=0 → after 26 cycles: quotient=0xFFFF, remainder=50000, dbz=1, sat=1.
- In DONE, change the operands to 50000/1100 with no go → auto-start and quotient=45, remainder=500. Reapply the same pair with no go → no start, ready stays 1. Pulse go → recomputes the same result.
- en held low for 5 cycles mid-RUN → ready arrives at cycle 31 with the correct quotient. go pulses during RUN → ignored, no second operation.
- rst at cycle 10 of RUN → next cycle: busy=0, ready=0, all outputs 0. A fresh 123456/100 after reset gives 1234.

Source files
------------

// File: rtl/seq_divider.sv
// Shared multi-cycle restoring divider: one quotient bit per enabled clock,
// Busy/Ready handshake, quotient saturated to WIDTH_Q bits.
module seq_divider #(
  parameter int unsigned WIDTH_N = 26,
  parameter int unsigned WIDTH_D = 26,
  parameter int unsigned WIDTH_Q = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               go,
  input  logic [WIDTH_N-1:0] dividend,
  input  logic [WIDTH_D-1:0] divisor,
  output logic               busy,
  output logic               ready,
  output logic [WIDTH_Q-1:0] quotient,
  output logic [WIDTH_D-1:0] remainder,
  output logic               sat,
  output logic               dbz
);

  localparam int unsigned CW = (WIDTH_N > 1) ? $clog2(WIDTH_N) : 1;
  localparam logic [WIDTH_N-1:0] QMAX = WIDTH_N'({WIDTH_Q{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [WIDTH_N-1:0] last_n_q, last_n_d;
  logic [WIDTH_D-1:0] last_d_q, last_d_d;
  logic [WIDTH_N-1:0] shift_q, shift_d;
  logic [WIDTH_D:0]   r_q, r_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH_Q-1:0] quot_q, quot_d;
  logic [WIDTH_D-1:0] rem_q, rem_d;
  logic               sat_q, sat_d;
  logic               dbz_q, dbz_d;

  logic               start;
  logic [WIDTH_D+1:0] r_shift;
  logic               q_bit;
  logic [WIDTH_D:0]   r_next;
  logic [WIDTH_N-1:0] shift_next;

  // The dividend shifts out MSB-first while quotient bits shift in at the LSB,
  // so after WIDTH_N steps shift_next holds the full quotient.
  always_comb begin
    state_d  = state_q;
    last_n_d = last_n_q;
    last_d_d = last_d_q;
    shift_d  = shift_q;
    r_d      = r_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    sat_d    = sat_q;
    dbz_d    = dbz_q;

    start      = (state_q != RUN) &&
                 (go || (dividend != last_n_q) || (divisor != last_d_q));
    r_shift    = {r_q, shift_q[WIDTH_N-1]};
    q_bit      = (r_shift >= (WIDTH_D+2)'(last_d_q));
    r_next     = q_bit ? (r_shift[WIDTH_D:0] - (WIDTH_D+1)'(last_d_q))
                       : r_shift[WIDTH_D:0];
    shift_next = {shift_q[WIDTH_N-2:0], q_bit};

    if (en) begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            last_n_d = dividend;
            last_d_d = divisor;
            shift_d  = dividend;
            r_d      = '0;
            cnt_d    = '0;
            sat_d    = 1'b0;
            dbz_d    = 1'b0;
            state_d  = RUN;
          end
        end
        RUN: begin
          shift_d = shift_next;
          r_d     = r_next;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH_N - 1)) begin
            state_d = DONE;
            cnt_d   = '0;
            if (last_d_q == '0) begin
              quot_d = '1;
              rem_d  = WIDTH_D'(last_n_q);
              sat_d  = 1'b1;
              dbz_d  = 1'b1;
            end else begin
              sat_d  = (shift_next > QMAX);
              quot_d = (shift_next > QMAX) ? '1 : shift_next[WIDTH_Q-1:0];
              rem_d  = r_next[WIDTH_D-1:0];
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_n_q <= '0;
      last_d_q <= '0;
      shift_q  <= '0;
      r_q      <= '0;
      cnt_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      sat_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_n_q <= last_n_d;
      last_d_q <= last_d_d;
      shift_q  <= shift_d;
      r_q      <= r_d;
      cnt_q    <= cnt_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      sat_q    <= sat_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign ready     = (state_q == DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign sat       = sat_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: fixed vectors, handshake corner sequences and
// randomized operands checked against an arithmetic reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        go = 1'b0;
  logic [25:0] dividend = '0;
  logic [25:0] divisor = '0;
  logic        busy, ready, sat, dbz;
  logic [15:0] quotient;
  logic [25:0] remainder;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH_N(26), .WIDTH_D(26), .WIDTH_Q(16)) dut (
    .clk(clk), .rst(rst), .en(en), .go(go),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .ready(ready), .quotient(quotient),
    .remainder(remainder), .sat(sat), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [25:0] n;
    logic [25:0] d;
    logic [15:0] q;
    logic [25:0] r;
    logic        s;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer division with saturation and zero-divisor rules.
  task automatic model(input logic [25:0] n, input logic [25:0] d,
                       output logic [15:0] q, output logic [25:0] r,
                       output logic s, output logic z);
    longint nq;
    if (d == 0) begin
      q = 16'hFFFF; r = n; s = 1'b1; z = 1'b1;
    end else begin
      nq = longint'(n) / longint'(d);
      r  = 26'(longint'(n) % longint'(d));
      s  = (nq > 65535);
      q  = s ? 16'hFFFF : 16'(nq);
      z  = 1'b0;
    end
  endtask

  task automatic run_op(input logic [25:0] n, input logic [25:0] d, input logic use_go,
                        input int stall_at, input int stall_len, input bit poke_go,
                        input logic [15:0] eq, input logic [25:0] er,
                        input logic es, input logic ez, input string tag);
    int cyc;
    bit done;
    @(negedge clk);
    dividend = n; divisor = d; go = use_go;
    @(posedge clk); #1;
    go = 1'b0;
    check({tag, ".busy_after_accept"}, busy, 1);
    check({tag, ".ready_cleared"}, ready, 0);
    cyc = 0; done = 0;
    while (!done && cyc < 200) begin
      @(posedge clk); cyc++; #1;
      if (stall_len > 0 && cyc == stall_at) en = 1'b0;
      if (stall_len > 0 && cyc == stall_at + stall_len) en = 1'b1;
      go = (poke_go && cyc == 3);
      if (ready) done = 1;
    end
    en = 1'b1;
    go = 1'b0;
    check({tag, ".completed"}, done, 1);
    check({tag, ".latency"}, cyc, 26 + stall_len);
    check({tag, ".busy_at_ready"}, busy, 0);
    check({tag, ".quotient"}, quotient, eq);
    check({tag, ".remainder"}, remainder, er);
    check({tag, ".sat"}, sat, es);
    check({tag, ".dbz"}, dbz, ez);
  endtask

  task automatic hold_check(input int ncyc, input string tag);
    repeat (ncyc) @(posedge clk);
    #1;
    check({tag, ".busy_held_low"}, busy, 0);
    check({tag, ".ready_held"}, ready, 1);
  endtask

  initial begin
    logic [15:0] mq;
    logic [25:0] mr, rn, rd;
    logic        ms, mz;
    int          sel;

    vecs[0] = '{26'd123456,   26'd100,      16'd1234,   26'd56,    1'b0, 1'b0};
    vecs[1] = '{26'd10000000, 26'd10,       16'hFFFF,   26'd0,     1'b1, 1'b0};
    vecs[2] = '{26'd50000,    26'd0,        16'hFFFF,   26'd50000, 1'b1, 1'b1};
    vecs[3] = '{26'd65535,    26'd1,        16'd65535,  26'd0,     1'b0, 1'b0};
    vecs[4] = '{26'd65536,    26'd1,        16'hFFFF,   26'd0,     1'b1, 1'b0};
    vecs[5] = '{26'd0,        26'd5,        16'd0,      26'd0,     1'b0, 1'b0};
    vecs[6] = '{26'd7,        26'd9,        16'd0,      26'd7,     1'b0, 1'b0};
    vecs[7] = '{26'd67108863, 26'd67108863, 16'd1,      26'd0,     1'b0, 1'b0};
    vecs[8] = '{26'd67108863, 26'd1024,     16'd65535,  26'd1023,  1'b0, 1'b0};
    vecs[9] = '{26'd0,        26'd0,        16'hFFFF,   26'd0,     1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", busy, 0);
    check("reset.ready", ready, 0);
    check("reset.quotient", quotient, 0);
    check("reset.remainder", remainder, 0);
    check("reset.sat", sat, 0);
    check("reset.dbz", dbz, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle.no_spurious_start", busy, 0);

    foreach (vecs[i])
      run_op(vecs[i].n, vecs[i].d, 1'b1, 0, 0, 1'b0,
             vecs[i].q, vecs[i].r, vecs[i].s, vecs[i].z, $sformatf("vec%0d", i));

    // Operand change alone starts; identical pair needs go.
    run_op(26'd50000, 26'd1100, 1'b0, 0, 0, 1'b0, 16'd45, 26'd500, 1'b0, 1'b0, "autostart");
    hold_check(5, "same_pair_no_go");
    run_op(26'd50000, 26'd1100, 1'b1, 0, 0, 1'b0, 16'd45, 26'd500, 1'b0, 1'b0, "rego");

    // Stall mid-run plus a go pulse that must be ignored.
    run_op(26'd123456, 26'd100, 1'b1, 10, 5, 1'b1, 16'd1234, 26'd56, 1'b0, 1'b0, "stall");
    hold_check(4, "go_in_run_not_queued");

    // Reset in the middle of a run.
    @(negedge clk);
    dividend = 26'd10000000; divisor = 26'd10; go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort.busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort.busy", busy, 0);
    check("abort.ready", ready, 0);
    check("abort.quotient", quotient, 0);
    check("abort.remainder", remainder, 0);
    check("abort.sat", sat, 0);
    check("abort.dbz", dbz, 0);
    rst = 1'b0;
    run_op(26'd123456, 26'd100, 1'b1, 0, 0, 1'b0, 16'd1234, 26'd56, 1'b0, 1'b0, "post_reset");

    for (int k = 0; k < 40; k++) begin
      rn  = 26'($urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) rd = '0;
      else if (sel < 5) rd = 26'($urandom_range(1, 2000));
      else if (sel < 7) rd = 26'($urandom_range(1, 1 << 14));
      else rd = 26'($urandom);
      if (sel == 1) rn = 26'($urandom_range(0, 100000));
      model(rn, rd, mq, mr, ms, mz);
      if (k % 2 == 1)
        run_op(rn, rd, 1'b1, $urandom_range(1, 20), $urandom_range(1, 4), 1'b0,
               mq, mr, ms, mz, $sformatf("rnd%0d", k));
      else
        run_op(rn, rd, 1'b1, 0, 0, 1'b0, mq, mr, ms, mz, $sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
